// File: rtl/muldiv_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide unit.
// Holds the funct3 op encodings, the FSM state type and its encoding,
// and small helpers that classify an op by operand signedness.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_CALC  = 2'd1;
    localparam state_t S_FIXUP = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    // rs1 is interpreted as two's complement for these ops
    function automatic logic op_signed_a(input logic [2:0] o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) ||
               (o == OP_DIV) || (o == OP_REM);
    endfunction

    // rs2 is interpreted as two's complement for these ops
    function automatic logic op_signed_b(input logic [2:0] o);
        return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Latency: start loads the operands, then XLEN iterations; done is high during the last one.
// No backpressure: results stay in quo/rem until the next start.
module muldiv_div_core import muldiv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    localparam int CW = $clog2(XLEN);

    logic            run;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Trial subtraction; a set MSB in diff means the divisor did not fit
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // done flags the cycle whose closing edge writes the final quotient bit
    assign done = run && (cnt == CW'(XLEN - 1));
    assign quo  = quo_q;
    assign rem  = rem_q;

    // Load on start, then shift one quotient bit in per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (run) begin
            rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
            cnt   <= cnt + CW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit; MULDIV_FAST_MUL_EN selects a one-shot multiplier.
// Latency: XLEN+2 cycles iterative, 2 cycles for div-by-zero, overflow and fast multiply.
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] r,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    state_t          state;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            rneg_q;
    logic            skip_q;
    logic [XLEN-1:0] skip_res_q;
    logic [XLEN-1:0] mc_q;
    logic [XLEN-1:0] phi;
    logic [XLEN-1:0] plo;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] r_q;

    logic            accept;
    logic            sa;
    logic            sb;
    logic [XLEN:0]   a_mag_w;
    logic [XLEN:0]   b_mag_w;
    logic            div0;
    logic            ovf;
    logic            skip;
    logic [XLEN-1:0] skip_res;
    logic            fast_mul;
    logic [XLEN:0]   msum;
    logic            calc_last;
    logic            div_start;
    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] fix_res;
    logic            unused_msb;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == S_IDLE) && !rst;
    assign busy      = (state != S_IDLE) && !rst;
    assign out_valid = (state == S_DONE) && !rst;
    assign r         = rst ? '0 : r_q;

    // Operand magnitudes in XLEN+1 bits so negating the most-negative value cannot wrap
    always_comb begin
        sa       = op_signed_a(op) & a[XLEN-1];
        sb       = op_signed_b(op) & b[XLEN-1];
        a_mag_w  = sa ? ((XLEN+1)'(0) - {1'b1, a}) : {1'b0, a};
        b_mag_w  = sb ? ((XLEN+1)'(0) - {1'b1, b}) : {1'b0, b};
        div0     = op[2] && (b == '0);
        ovf      = ((op == OP_DIV) || (op == OP_REM)) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        skip     = div0 || ovf;
        skip_res = '0;
        if (div0) begin
            skip_res = op[1] ? a : '1;
        end else if (ovf) begin
            skip_res = op[1] ? '0 : a;
        end
    end

    // The magnitude MSB is always clear; it exists only to absorb the negation carry
    assign unused_msb = a_mag_w[XLEN] ^ b_mag_w[XLEN];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag_w[XLEN-1:0]} * {{XLEN{1'b0}}, b_mag_w[XLEN-1:0]};
    assign fast_mul  = !op[2];
`else
    assign fast_mul  = 1'b0;
`endif

    // One shift-add step: add the multiplicand when the current multiplier bit is set
    assign msum      = {1'b0, phi} + {1'b0, (plo[0] ? mc_q : {XLEN{1'b0}})};
    assign calc_last = op_q[2] ? div_done : (cnt == CW'(XLEN - 1));
    assign div_start = accept && op[2] && !skip;

    muldiv_div_core #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_mag_w[XLEN-1:0]),
        .divisor  (b_mag_w[XLEN-1:0]),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    // Sign fixup and result selection; quotient sign is a^b, remainder follows the dividend
    always_comb begin
        logic [2*XLEN-1:0] prod_s;
        logic [XLEN-1:0]   quo_s;
        logic [XLEN-1:0]   rem_s;
        prod_s  = neg_q  ? ((2*XLEN)'(0) - {phi, plo}) : {phi, plo};
        quo_s   = neg_q  ? (XLEN'(0) - div_quo) : div_quo;
        rem_s   = rneg_q ? (XLEN'(0) - div_rem) : div_rem;
        fix_res = rem_s;
        if (skip_q) begin
            fix_res = skip_res_q;
        end else begin
            case (op_q)
                OP_MUL:                        fix_res = prod_s[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:               fix_res = quo_s;
                default:                       fix_res = rem_s;
            endcase
        end
    end

    // Control FSM plus the iterative multiplier datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            skip_q     <= 1'b0;
            skip_res_q <= '0;
            mc_q       <= '0;
            phi        <= '0;
            plo        <= '0;
            cnt        <= '0;
            r_q        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= op;
                        neg_q      <= sa ^ sb;
                        rneg_q     <= sa;
                        skip_q     <= skip;
                        skip_res_q <= skip_res;
                        mc_q       <= a_mag_w[XLEN-1:0];
                        phi        <= '0;
                        plo        <= b_mag_w[XLEN-1:0];
                        cnt        <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        if (fast_mul) begin
                            {phi, plo} <= fast_prod;
                        end
`endif
                        state      <= (skip || fast_mul) ? S_FIXUP : S_CALC;
                    end
                end
                S_CALC: begin
                    if (!op_q[2]) begin
                        phi <= msum[XLEN:1];
                        plo <= {msum[0], plo[XLEN-1:1]};
                        cnt <= cnt + CW'(1);
                    end
                    if (calc_last) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_q   <= fix_res;
                    state <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, shall set the operand and result width in bits; legal values are 8..64, even.
REQ-002 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  shall be the reset: synchronous, active-high.
REQ-004 in_valid  input  1  shall indicate that a request is presented.
REQ-005 in_ready  output  1  shall indicate that a request is accepted this cycle.
REQ-006 op  input  3  shall carry the RISC-V M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a, b  input  XLEN  shall carry operand rs1 and operand rs2.
REQ-008 out_valid  output  1  shall indicate that a result is presented.
REQ-009 out_ready  input  1  shall indicate that the consumer accepts the result.
REQ-010 r  output  XLEN  shall carry the result.
REQ-011 busy  output  1  shall be high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, CALC, FIXUP, DONE.
REQ-013 in_ready shall be 1 only in IDLE; a request is accepted when in_valid and in_ready are both high; on acceptance, a, b and op are registered.
REQ-014 Transitions: IDLE->CALC on acceptance; CALC->FIXUP after exactly XLEN iterations; FIXUP->DONE after 1 cycle; DONE->IDLE when out_ready is high.
REQ-015 Latency: for acceptance at edge N, out_valid shall rise at edge N+XLEN+2.
REQ-016 out_valid and r shall be held stable in DONE until out_ready is high; a new request shall not be accepted in the cycle out_ready is high.
REQ-017 Multiply shall use radix-2 shift-add on magnitudes with sign fixup in FIXUP, producing a 2*XLEN-bit product.
REQ-018 MUL shall return the low XLEN bits of the product; MULH, MULHSU and MULHU shall return the high XLEN bits, with the operands treated as signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-019 Divide shall use radix-2 restoring division on magnitudes; the quotient sign is a^b (signed ops); the remainder sign follows the dividend.
REQ-020 Divide by zero: DIV/DIVU shall return all-ones; REM/REMU shall return a; this path shall skip CALC (IDLE->FIXUP), giving out_valid at N+2.
REQ-021 Signed overflow (a = -2^(XLEN-1), b = -1): DIV shall return a; REM shall return 0; this path shall skip CALC.
REQ-022 All internal arithmetic shall be XLEN+1 bits wide to avoid overflow when negating the most-negative value.
REQ-023 in_valid high while busy shall have no effect; the request shall be retried by the producer.

Reset
REQ-024 While rst is high, the FSM shall go to IDLE; out_valid=0, r=0, busy=0, in_ready=0.
REQ-025 On the first cycle after rst falls, in_ready shall be 1.
REQ-026 Reset asserted mid-CALC or in DONE shall abort the operation with no output.

Configuration
REQ-027 Macro MULDIV_FAST_MUL_EN defined: the multiply ops shall use a single-cycle combinational XLEN×XLEN multiplier and go IDLE->FIXUP, giving out_valid at N+2; divide is unchanged.
REQ-028 Macro MULDIV_FAST_MUL_EN undefined: the multiply ops shall use the iterative path per REQ-015.

Structure
REQ-029 Package muldiv_pkg shall hold the op encoding constants, the FSM state typedef, and the state encoding.
REQ-030 The iteration datapath for division shall be the sub-module muldiv_div_core (one quotient bit per cycle, start/done handshake); multiply, sign fixup and the FSM remain in the top level.

Verification (XLEN=32)
REQ-031 DIV a=-7, b=2 -> r=0xFFFFFFFD (-3); REM with the same operands -> r=0xFFFFFFFF (-1); out_valid at N+34.
REQ-032 DIVU a=100, b=0 -> r=0xFFFFFFFF at N+2; REMU a=100, b=0 -> r=100.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> r=0x80000000; REM with the same operands -> r=0.
REQ-034 MULH a=0x80000000, b=0x80000000 -> r=0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> r=0xFFFFFFFF; MULHU with the same operands -> r=0xFFFFFFFE.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> r and out_valid are stable and in_ready=0; pulse rst during CALC -> IDLE on the next edge and out_valid is never asserted.
REQ-036 With MULDIV_FAST_MUL_EN defined, MUL a=3, b=-4 -> r=0xFFFFFFF4 at N+2.
